// File: rtl/sram_req_master_pkg.sv
// sram_req_pkg
// Shared constants for the SRAM request master and its response FIFO.
//   - default bus widths and response FIFO depth
//   - response-entry layout: {write_flag, data} when write acknowledges are
//     built in (SRAM_WR_RESP_EN), plain data otherwise
//   - access-kind enum used to track what the in-flight access was
package sram_req_pkg;

  localparam int SRAM_DATA_WIDTH_DEF = 32;
  localparam int SRAM_ADDR_WIDTH_DEF = 10;
  localparam int RSP_DEPTH_DEF       = 4;

  typedef enum logic {
    ACC_READ  = 1'b0,
    ACC_WRITE = 1'b1
  } acc_kind_e;

  // Data occupies the low bits of a response entry.
  function automatic int rsp_data_lsb();
    return 0;
  endfunction

  // The write flag sits directly above the data.
  function automatic int rsp_write_bit(input int data_width);
    return data_width;
  endfunction

  // Total entry width for a given data width and feature setting.
  function automatic int rsp_entry_width(input int data_width, input bit with_write_flag);
    return with_write_flag ? data_width + 1 : data_width;
  endfunction

endpackage

// File: rtl/sram_req_master_if.sv
// sram_req_master_if
// Bundles the client request stream, the response stream and the SRAM bus.
//   master modport : the bridge (drives req_ready, rsp_*, sram_en/we/addr/din)
//   slave modport  : client + SRAM side (drives req_*, rsp_ready, sram_dout)
// Handshake rule for both streams: a beat transfers on a rising edge where
// valid && ready; once valid is raised, the payload stays stable until that
// transfer. req_ready never looks at req_valid.
interface sram_req_master_if
  import sram_req_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH_DEF
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  req_valid;
  logic                  req_ready;
  logic [NB-1:0]         req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_write;

  logic                  sram_en;
  logic [NB-1:0]         sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [DATA_WIDTH-1:0] sram_din;
  logic [DATA_WIDTH-1:0] sram_dout;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_dout,
    output req_ready, rsp_valid, rsp_rdata, rsp_write,
           sram_en, sram_we, sram_addr, sram_din
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready, sram_dout,
    input  req_ready, rsp_valid, rsp_rdata, rsp_write,
           sram_en, sram_we, sram_addr, sram_din
  );

endinterface

// File: rtl/sram_req_master_rsp_fifo.sv
// sram_rsp_fifo
// Synchronous FIFO holding response beats; the head entry is visible on rdata
// without a pop (first-word fall-through). A push and a pop in the same cycle
// are allowed at any fill level, including full.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata this cycle
//   pop      : drop the head entry (ignored when empty)
//   rdata    : head entry, zero while empty
//   count    : number of stored entries (0..DEPTH)
//   full     : count == DEPTH
//   empty    : count == 0
module sram_rsp_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             pop_eff;

  always_comb begin
    pop_eff  = pop & (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    // DEPTH is a power of two, so pointers wrap by natural overflow.
    if (push)    wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_eff) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop_eff})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: nothing is visible while count is zero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  assign rdata = empty ? '0 : mem_q[rd_ptr_q];

`ifndef SYNTHESIS
  // The credit scheme bounds outstanding accesses to DEPTH, so a push into a
  // full FIFO that is not popped the same cycle means the accounting broke.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && full && !pop));
`endif

endmodule

// File: rtl/sram_req_master.sv
// sram_req_master
// Bridge from a valid/ready request stream to a byte-enabled single-port SRAM
// with 1-cycle synchronous read; read data returns on a valid/ready response
// stream with full backpressure.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sram_req_master_if.master
//              req_valid/req_ready/req_we/req_addr/req_wdata  (client in)
//              rsp_valid/rsp_ready/rsp_rdata/rsp_write        (client out)
//              sram_en/sram_we/sram_addr/sram_din/sram_dout   (SRAM)
// Optional feature macro: SRAM_WR_RESP_EN -- writes also return an
// acknowledge beat (rsp_write=1, rsp_rdata=0) in order with reads.
//
// Timing: an access issued on the edge ending cycle T is "pending" during
// T+1, its result enters the FIFO on the edge ending T+1, and the beat is
// visible from T+2. Each pending access or stored beat holds one credit;
// req_ready is high while credits remain, so the FIFO cannot overflow.
module sram_req_master
  import sram_req_pkg::*;
#(
  parameter int DATA_WIDTH = SRAM_DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = SRAM_ADDR_WIDTH_DEF,
  parameter int RSP_DEPTH  = RSP_DEPTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sram_req_master_if.master  bus
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int CW = $clog2(RSP_DEPTH) + 1;
`ifdef SRAM_WR_RESP_EN
  localparam int EW = rsp_entry_width(DATA_WIDTH, 1'b1);
`else
  localparam int EW = rsp_entry_width(DATA_WIDTH, 1'b0);
`endif

  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_push;
  logic          fifo_pop;
  logic [EW-1:0] fifo_wdata;
  logic [EW-1:0] fifo_rdata;

  logic          rd_pending_q, rd_pending_d;
  logic [CW:0]   credits_used;
  logic          req_ready;
  logic          issue;
  logic          is_write;

`ifdef SRAM_WR_RESP_EN
  acc_kind_e     pend_kind_q, pend_kind_d;
`endif

  always_comb begin
    // Only registered state feeds req_ready.
    credits_used = {1'b0, fifo_count} + (CW+1)'(rd_pending_q);
    req_ready    = credits_used < (CW+1)'(RSP_DEPTH);
    issue        = bus.req_valid & req_ready & ~rst;
    is_write     = (bus.req_we != '0);
`ifdef SRAM_WR_RESP_EN
    rd_pending_d = issue;
    pend_kind_d  = is_write ? ACC_WRITE : ACC_READ;
`else
    // Writes are fire-and-forget: no credit, no beat.
    rd_pending_d = issue & ~is_write;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pending_q <= 1'b0;
`ifdef SRAM_WR_RESP_EN
      pend_kind_q  <= ACC_READ;
`endif
    end else begin
      rd_pending_q <= rd_pending_d;
`ifdef SRAM_WR_RESP_EN
      pend_kind_q  <= pend_kind_d;
`endif
    end
  end

  // The SRAM result of the pending access is captured at the end of its
  // pending cycle.
  always_comb begin
    fifo_push = rd_pending_q;
    fifo_pop  = bus.rsp_ready & ~fifo_empty;
`ifdef SRAM_WR_RESP_EN
    if (pend_kind_q == ACC_WRITE) fifo_wdata = {1'b1, {DATA_WIDTH{1'b0}}};
    else                          fifo_wdata = {1'b0, bus.sram_dout};
`else
    fifo_wdata = bus.sram_dout;
`endif
  end

  sram_rsp_fifo #(
    .WIDTH (EW),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (fifo_wdata),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.req_ready = req_ready;
  assign bus.sram_en   = issue;
  assign bus.sram_we   = issue ? bus.req_we : {NB{1'b0}};
  assign bus.sram_addr = bus.req_addr;
  assign bus.sram_din  = bus.req_wdata;

  assign bus.rsp_valid = ~fifo_empty;
  assign bus.rsp_rdata = fifo_rdata[rsp_data_lsb() +: DATA_WIDTH];
`ifdef SRAM_WR_RESP_EN
  assign bus.rsp_write = fifo_rdata[rsp_write_bit(DATA_WIDTH)];
`else
  assign bus.rsp_write = 1'b0;
`endif

endmodule

// File: tb/tb_sram_req_master.sv
// tb_sram_req_master
// Directed bench for sram_req_master with an SRAM model, a transaction-level
// scoreboard checked every cycle, and literal expectations per scenario.
module tb_sram_req_master;
  import sram_req_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 10;
  localparam int DEPTH = 4;

  logic clk;
  logic rst;

  sram_req_master_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sram_req_master #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .RSP_DEPTH  (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- SRAM model (default contents: word a holds a*3) --------
  logic [DW-1:0] sram_mem [1024];
  bit            sram_wr  [1024];

  initial bus.sram_dout = '0;
  always @(posedge clk) begin
    if (bus.sram_en) begin
      if (bus.sram_we != '0) begin
        logic [DW-1:0] w;
        w = sram_wr[bus.sram_addr] ? sram_mem[bus.sram_addr] : 32'(bus.sram_addr * 3);
        for (int b = 0; b < 4; b++)
          if (bus.sram_we[b]) w[8*b +: 8] = bus.sram_din[8*b +: 8];
        sram_mem[bus.sram_addr] <= w;
        sram_wr[bus.sram_addr]  <= 1'b1;
      end else begin
        bus.sram_dout <= sram_wr[bus.sram_addr] ? sram_mem[bus.sram_addr]
                                                : 32'(bus.sram_addr * 3);
      end
    end
  end

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int acc_cnt = 0;
  int en_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard model ----------------
  // Every accepted read (and, with write acks, every write) becomes an
  // expected beat visible two cycles after acceptance; outstanding beats
  // (accepted, not yet consumed) may never exceed DEPTH.
  logic [DW:0]   exp_q [$];   // {write_flag, data}
  int            vis_q [$];
  logic [DW-1:0] ref_mem [1024];
  bit            ref_wr  [1024];

  logic [DW:0]   log_q   [$];  // beats observed leaving the DUT
  int            log_cyc [$];
  int            acc_cyc_q [$];

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_wr[a] ? ref_mem[a] : 32'(a * 3);
  endfunction

  always @(negedge clk) begin
    logic exp_ready, exp_valid, exp_en;
    cyc++;
    if (rst) begin
      exp_q.delete();
      vis_q.delete();
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_write", bus.rsp_write, 0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 0);
      chk("rst_sram_en",   bus.sram_en,   0);
      chk("rst_sram_we",   bus.sram_we,   0);
    end else begin
      exp_ready = (exp_q.size() < DEPTH);
      exp_valid = 1'b0;
      if (exp_q.size() > 0) exp_valid = (vis_q[0] <= cyc);
      chk("req_ready", bus.req_ready, exp_ready);
      chk("rsp_valid", bus.rsp_valid, exp_valid);
      if (exp_valid) begin
        chk("rsp_rdata", bus.rsp_rdata, exp_q[0][DW-1:0]);
        chk("rsp_write", bus.rsp_write, exp_q[0][DW]);
      end
      exp_en = bus.req_valid && exp_ready;
      chk("sram_en", bus.sram_en, exp_en);
      chk("sram_we", bus.sram_we, exp_en ? bus.req_we : 4'h0);
      if (exp_en) begin
        chk("sram_addr", bus.sram_addr, bus.req_addr);
        chk("sram_din",  bus.sram_din,  bus.req_wdata);
      end
      // advance the model across the coming edge
      if (bus.rsp_valid && bus.rsp_ready) begin
        log_q.push_back({bus.rsp_write, bus.rsp_rdata});
        log_cyc.push_back(cyc);
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_cnt++;
        acc_cyc_q.push_back(cyc);
      end
      if (bus.sram_en) en_cnt++;
      if (exp_valid && bus.rsp_ready) begin
        void'(exp_q.pop_front());
        void'(vis_q.pop_front());
      end
      if (exp_en) begin
        if (bus.req_we != '0) begin
          logic [DW-1:0] w;
          w = ref_rd(bus.req_addr);
          for (int b = 0; b < 4; b++)
            if (bus.req_we[b]) w[8*b +: 8] = bus.req_wdata[8*b +: 8];
          ref_mem[bus.req_addr] = w;
          ref_wr[bus.req_addr]  = 1'b1;
`ifdef SRAM_WR_RESP_EN
          exp_q.push_back({1'b1, {DW{1'b0}}});
          vis_q.push_back(cyc + 2);
`endif
        end else begin
          exp_q.push_back({1'b0, ref_rd(bus.req_addr)});
          vis_q.push_back(cyc + 2);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [3:0] we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
    int   n;
    logic a;
    n = 0;
    a = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    while (!a && n < 200) begin
      @(negedge clk);
      a = bus.req_ready;
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (!a) begin
      errors++;
      $display("FAIL req_accept_timeout: got not-accepted expected accepted addr=0x%0h", addr);
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic clear_logs();
    log_q.delete();
    log_cyc.delete();
    acc_cyc_q.delete();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int a0, e0, i, n;
    logic acc;
    logic [DW-1:0] rd_vals [$];
    int            rd_cyc  [$];

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(1);
    chk("post_reset_req_ready", bus.req_ready, 1);

    // 1: reset mid-burst with reads outstanding
    clear_logs();
    do_req(4'h0, 10'd1, '0);
    do_req(4'h0, 10'd2, '0);
    chk("t1_beat_before_reset", bus.rsp_valid, 1);
    rst = 1'b1;
    #1;
    chk("t1_rsp_valid_async", bus.rsp_valid, 0);
    idle(2);
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    idle(6);
    chk("t1_no_stale_beats", log_q.size(), 0);
    chk("t1_req_ready", bus.req_ready, 1);

    // 3: streaming 16 reads with rsp_ready high
    clear_logs();
    for (int k = 0; k < 16; k++) do_req(4'h0, AW'(k), '0);
    idle(5);
    chk("t3_beats", log_q.size(), 16);
    chk("t3_accepts", acc_cyc_q.size(), 16);
    if (log_q.size() == 16 && acc_cyc_q.size() == 16) begin
      chk("t3_first_data", log_q[0], 33'd0);
      chk("t3_last_data",  log_q[15], 33'd45);
      chk("t3_issue_span", acc_cyc_q[15] - acc_cyc_q[0], 15);
      chk("t3_beat_span",  log_cyc[15] - log_cyc[0], 15);
      chk("t3_latency",    log_cyc[0] - acc_cyc_q[0], 2);
    end

    // 4: backpressure, 6 reads offered with rsp_ready low
    clear_logs();
    bus.rsp_ready = 1'b0;
    a0 = acc_cnt;
    e0 = en_cnt;
    i  = 0;
    for (int k = 0; k < 10; k++) begin
      bus.req_valid = (i < 6);
      bus.req_we    = 4'h0;
      bus.req_addr  = AW'(i);
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #1;
      if (acc && bus.req_valid) i++;
    end
    chk("t4_accepted", acc_cnt - a0, 4);
    chk("t4_en_pulses", en_cnt - e0, 4);
    chk("t4_req_ready_low", bus.req_ready, 0);
    bus.rsp_ready = 1'b1;
    n = 0;
    while (i < 6 && n < 50) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = AW'(i);
      @(negedge clk);
      acc = bus.req_ready;
      @(posedge clk);
      #1;
      if (acc) i++;
      n++;
    end
    bus.req_valid = 1'b0;
    idle(8);
    chk("t4_beats", log_q.size(), 6);
    if (log_q.size() == 6)
      for (int k = 0; k < 6; k++) chk("t4_order", log_q[k], 33'(k * 3));
    chk("t4_req_ready_back", bus.req_ready, 1);

    // 5: pop and refill while full
    clear_logs();
    bus.rsp_ready = 1'b0;
    for (int k = 8; k < 12; k++) do_req(4'h0, AW'(k), '0);
    idle(3);
    chk("t5_full_ready_low", bus.req_ready, 0);
    a0 = acc_cnt;
    bus.req_valid = 1'b1;
    bus.req_we    = 4'h0;
    bus.req_addr  = 10'd12;
    bus.rsp_ready = 1'b1;
    idle(1);
    bus.rsp_ready = 1'b0;
    idle(1);
    bus.req_valid = 1'b0;
    idle(3);
    chk("t5_one_pop", log_q.size(), 1);
    chk("t5_one_accept", acc_cnt - a0, 1);
    chk("t5_refull_ready_low", bus.req_ready, 0);
    bus.rsp_ready = 1'b1;
    idle(8);
    chk("t5_beats", log_q.size(), 5);
    if (log_q.size() == 5)
      for (int k = 0; k < 5; k++) chk("t5_order", log_q[k], 33'((k + 8) * 3));

    // 2: write then read of the same word, full and partial byte enables
    clear_logs();
    do_req(4'hF, 10'h005, 32'hDEADBEEF);
    do_req(4'h0, 10'h005, '0);
    do_req(4'b0010, 10'h005, 32'h0000AA00);
    do_req(4'h0, 10'h005, '0);
    idle(6);
    rd_vals.delete();
    rd_cyc.delete();
    for (int k = 0; k < log_q.size(); k++)
      if (!log_q[k][DW]) begin
        rd_vals.push_back(log_q[k][DW-1:0]);
        rd_cyc.push_back(log_cyc[k]);
      end
    chk("t2_read_beats", rd_vals.size(), 2);
    if (rd_vals.size() == 2 && acc_cyc_q.size() == 4) begin
      chk("t2_full_write", rd_vals[0], 32'hDEADBEEF);
      chk("t2_byte_write", rd_vals[1], 32'hDEADAAEF);
      chk("t2_latency", rd_cyc[0] - acc_cyc_q[1], 2);
    end

    // 6: W, R, W beat sequence
    clear_logs();
    do_req(4'hF, 10'd20, 32'h11223344);
    do_req(4'h0, 10'd20, '0);
    do_req(4'hF, 10'd21, 32'h55667788);
    idle(6);
`ifdef SRAM_WR_RESP_EN
    chk("t6_beats", log_q.size(), 3);
    if (log_q.size() == 3) begin
      chk("t6_beat0", log_q[0], {1'b1, 32'h0});
      chk("t6_beat1", log_q[1], {1'b0, 32'h11223344});
      chk("t6_beat2", log_q[2], {1'b1, 32'h0});
    end
`else
    chk("t6_beats", log_q.size(), 1);
    if (log_q.size() == 1) chk("t6_beat0", log_q[0], {1'b0, 32'h11223344});
`endif

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
